// File: rtl/axis_nconv_v1_if.sv
// rtl/axis_nconv_v1_if.sv - AXI4-Stream beat interface used on both sides of the narrowing converter
// Purpose: one stream channel of width W (tvalid/tready/tdata).
// Modports:
//   master - drives tvalid, tdata; receives tready
//   slave  - receives tvalid, tdata; drives tready
interface axis_nconv_v1_if #(
  parameter int W = 256
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_nconv_v1.sv
// rtl/axis_nconv_v1.sv - 256-bit to 192-bit AXI4-Stream narrowing converter with full backpressure
// Purpose: re-slices the input bitstream (first beat in the LSBs) into 192-bit beats;
//          every 3 input beats yield exactly 4 output beats, bit order preserved.
// Ports:
//   aclk    - clock
//   aresetn - asynchronous active-low reset
//   s_axis  - 256-bit input stream (slave side: tvalid/tdata in, tready out)
//   m_axis  - 192-bit output stream (master side: tvalid/tdata out, tready in)
module axis_nconv_v1 (
  input  logic            aclk,
  input  logic            aresetn,
  axis_nconv_v1_if.slave  s_axis,
  axis_nconv_v1_if.master m_axis
);

  localparam int unsigned LANE_W = 64;
  localparam int unsigned N_LANE = 10;
  localparam int unsigned BUF_W  = LANE_W * N_LANE;
  localparam int unsigned OUT_W  = 3 * LANE_W;

  // Ten 64-bit lanes, lane 0 oldest; r_level counts valid lanes (0..10).
  logic [BUF_W-1:0] r_buf;
  logic [3:0]       r_level;
  logic             r_ready_en;

  logic             w_s_fire;
  logic             w_m_fire;
  logic [3:0]       w_p;
  logic [3:0]       w_level_nxt;
  logic [BUF_W-1:0] w_buf_nxt;

  // Ready is a function of registered state only, so there is no
  // combinational path from m_axis.tready or s_axis.tvalid.
  assign s_axis.tready = r_ready_en & (r_level <= 4'd6);
  assign m_axis.tvalid = (r_level >= 4'd3);
  assign m_axis.tdata  = r_buf[$bits(m_axis.tdata)-1:0];

  assign w_s_fire = s_axis.tvalid & s_axis.tready;
  assign w_m_fire = m_axis.tvalid & m_axis.tready;

  // Write position is taken after the output shift, so a simultaneous
  // input and output beat completes in a single cycle.
  assign w_p         = w_m_fire ? (r_level - 4'd3) : r_level;
  assign w_level_nxt = r_level + (w_s_fire ? 4'd4 : 4'd0) - (w_m_fire ? 4'd3 : 4'd0);

  always_comb begin
    w_buf_nxt = w_m_fire ? {{OUT_W{1'b0}}, r_buf[BUF_W-1:OUT_W]} : r_buf;
    if (w_s_fire) begin
      // Lane k receives input lane j when k == p + j; constant indices only.
      for (int k = 0; k < int'(N_LANE); k++) begin
        for (int j = 0; j < 4; j++) begin
          if ((w_p + 4'(j)) == 4'(k)) begin
            w_buf_nxt[k*LANE_W +: LANE_W] = s_axis.tdata[j*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_buf      <= '0;
      r_level    <= 4'd0;
      r_ready_en <= 1'b0;
    end else begin
      // Holds input off for the first cycle after reset release.
      r_ready_en <= 1'b1;
      r_buf      <= w_buf_nxt;
      r_level    <= w_level_nxt;
    end
  end

endmodule

// File: tb/tb_axis_nconv_v1.sv
// tb/tb_axis_nconv_v1.sv - self-checking bench for the 256-to-192 narrowing converter
module tb_axis_nconv_v1;

  logic aclk;
  logic aresetn;

  axis_nconv_v1_if #(.W(256)) s_if ();
  axis_nconv_v1_if #(.W(192)) m_if ();

  axis_nconv_v1 dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    vec_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [255:0] ramp_word(input logic [15:0] b);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = b + 16'(k);
    return w;
  endfunction

  function automatic logic [191:0] ramp_out(input logic [15:0] b);
    logic [191:0] w;
    for (int k = 0; k < 12; k++) w[k*16 +: 16] = b + 16'(k);
    return w;
  endfunction

  // Bitstream scoreboard: queue of 64-bit lanes in stream order.
  logic [63:0] q[$];
  int          out_cnt = 0;
  bit          chk_rdy = 1'b0;
  logic        sb_sf;
  logic        sb_mf;

  always @(negedge aclk) begin
    if (!aresetn) begin
      q.delete();
    end else begin
      sb_sf = s_if.tvalid & s_if.tready;
      sb_mf = m_if.tvalid & m_if.tready;
      chk("m_tvalid", 256'(m_if.tvalid), 256'(q.size() >= 3));
      if (chk_rdy) chk("s_tready", 256'(s_if.tready), 256'(q.size() <= 6));
      if (sb_mf) begin
        if (q.size() >= 3) begin
          chk("m_tdata", 256'(m_if.tdata), 256'({q[2], q[1], q[0]}));
          repeat (3) void'(q.pop_front());
        end
        out_cnt++;
      end
      if (sb_sf) begin
        for (int k = 0; k < 4; k++) q.push_back(s_if.tdata[k*64 +: 64]);
      end
      if (sb_sf || sb_mf) chk("occupancy_over_10", 256'(q.size() > 10), 256'(0));
    end
  end

  typedef struct packed {
    logic         rstn;
    logic         sv;
    logic [255:0] sd;
    logic         mr;
    logic         exp_sr;
    logic         exp_mv;
    logic         chk_d;
    logic [191:0] exp_md;
  } vec_t;

  vec_t tbl [8];

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      aresetn      = tbl[i].rstn;
      s_if.tvalid  = tbl[i].sv;
      s_if.tdata   = tbl[i].sd;
      m_if.tready  = tbl[i].mr;
      @(negedge aclk);
      chk($sformatf("tbl%0d_s_tready", i), 256'(s_if.tready), 256'(tbl[i].exp_sr));
      chk($sformatf("tbl%0d_m_tvalid", i), 256'(m_if.tvalid), 256'(tbl[i].exp_mv));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_m_tdata", i), 256'(m_if.tdata), 256'(tbl[i].exp_md));
      tick();
    end
  endtask

  int sent;
  int acc;
  int base_out;
  int last_low;
  int gaps;
  bit first_seen;

  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;

    tbl[0] = '{1'b0, 1'b0, 256'd0,          1'b1, 1'b0, 1'b0, 1'b0, 192'd0};
    tbl[1] = '{1'b1, 1'b1, ramp_word(16'd0),  1'b1, 1'b0, 1'b0, 1'b0, 192'd0};
    tbl[2] = '{1'b1, 1'b1, ramp_word(16'd0),  1'b1, 1'b1, 1'b0, 1'b0, 192'd0};
    tbl[3] = '{1'b1, 1'b1, ramp_word(16'd16), 1'b1, 1'b1, 1'b1, 1'b1, ramp_out(16'd0)};
    tbl[4] = '{1'b1, 1'b1, ramp_word(16'd32), 1'b1, 1'b1, 1'b1, 1'b1, ramp_out(16'd12)};
    tbl[5] = '{1'b1, 1'b0, 256'd0,          1'b1, 1'b1, 1'b1, 1'b1, ramp_out(16'd24)};
    tbl[6] = '{1'b1, 1'b0, 256'd0,          1'b1, 1'b1, 1'b1, 1'b1, ramp_out(16'd36)};
    tbl[7] = '{1'b1, 1'b0, 256'd0,          1'b1, 1'b1, 1'b0, 1'b0, 192'd0};

    #1;
    // Reset release and stream order.
    run_table();

    // Mid-stream reset after two input beats and one output beat.
    s_if.tvalid = 1'b1;
    s_if.tdata  = ~ramp_word(16'd500);
    m_if.tready = 1'b0;
    tick();
    s_if.tdata  = ~ramp_word(16'd516);
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    aresetn     = 1'b0;
    #1;
    chk("rst_async_s_tready", 256'(s_if.tready), 256'(0));
    chk("rst_async_m_tvalid", 256'(m_if.tvalid), 256'(0));
    run_table();
    chk_rdy = 1'b1;

    // Full-rate streaming: 300 beats, tvalid and tready held high.
    sent = 0; base_out = out_cnt; last_low = -1; gaps = 0; first_seen = 1'b0;
    m_if.tready = 1'b1;
    for (int c = 0; c < 2000 && sent < 300; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = ramp_word(16'(sent * 16));
      @(negedge aclk);
      if (m_if.tvalid) first_seen = 1'b1;
      else if (first_seen) gaps++;
      if (!s_if.tready) begin
        if (last_low >= 0) chk("stream_tready_low_period", 256'(c - last_low), 256'(4));
        last_low = c;
      end
      if (s_if.tvalid && s_if.tready) sent++;
      tick();
    end
    chk("stream_beats_sent", 256'(sent), 256'(300));
    chk("stream_tvalid_gaps", 256'(gaps), 256'(0));
    s_if.tvalid = 1'b0;
    repeat (6) tick();
    chk("stream_out_beats", 256'(out_cnt - base_out), 256'(400));
    chk("stream_drained_tvalid", 256'(m_if.tvalid), 256'(0));

    // Backpressure: stall output, offer beats continuously.
    acc = 0; base_out = out_cnt;
    m_if.tready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = ramp_word(16'(16000 + acc * 16));
      @(negedge aclk);
      if (m_if.tvalid) chk("bp_stall_tdata", 256'(m_if.tdata), 256'(ramp_out(16'd16000)));
      if (s_if.tvalid && s_if.tready) acc++;
      tick();
    end
    chk("bp_accepted", 256'(acc), 256'(2));
    chk("bp_s_tready", 256'(s_if.tready), 256'(0));
    chk("bp_m_tvalid", 256'(m_if.tvalid), 256'(1));
    m_if.tready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_if.tvalid = (acc < 3);
      s_if.tdata  = ramp_word(16'(16000 + acc * 16));
      @(negedge aclk);
      if (s_if.tvalid && s_if.tready) acc++;
      tick();
    end
    chk("bp_total_in", 256'(acc), 256'(3));
    chk("bp_out_beats", 256'(out_cnt - base_out), 256'(4));
    chk("bp_drained_tvalid", 256'(m_if.tvalid), 256'(0));

    // Random tvalid/tready against the scoreboard.
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      s_if.tvalid = 1'($urandom % 2);
      s_if.tdata  = ramp_word(16'(sent * 16)) ^ {8{32'h5a5a_0000 | 32'(sent)}};
      m_if.tready = 1'($urandom % 2);
      @(negedge aclk);
      if (s_if.tvalid && s_if.tready) sent++;
      tick();
    end
    chk("rand_beats_sent", 256'(sent), 256'(10000));
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (8) tick();
    chk("rand_drained_tvalid", 256'(m_if.tvalid), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
